input_skew_buffer: RTL and testbench
====================================

Name: input_skew_buffer

Overview:
- Sits directly downstream of the input router and upstream of the PE array's row inputs.
- Takes the per-row activation words and their valids, and staggers row r by r cycles, giving the diagonal wavefront the systolic array expects.
- Tracks the end of a tile: after the router signals completion, the block drains its delay lines and pulses a drain-done flag to the top-level sequencer.
- Supports a synchronous stall (array back-pressure) and a sticky overrun flag.

Parameters:
- DATA_WIDTH, 8, width of one activation word per row
- ROWS, 4, number of array rows / delay lanes
- ADDR_WIDTH, 8, width of the accepted-vector counter

Ports:
- i_clk  input  1  clock
- i_nrst  input  1  asynchronous active-low reset
- i_en  input  1  block enable; when low, no new data is accepted and state is held
- i_reg_clear  input  1  synchronous clear of all lanes, counters, flags and FSM
- i_stall  input  1  array back-pressure; freezes all lanes when high
- i_data  input  ROWS*DATA_WIDTH  per-row input words, packed [ROWS-1:0][DATA_WIDTH-1:0]
- i_data_valid  input  ROWS  per-row input valid
- i_route_done  input  1  one-cycle pulse from the router: last vector has been presented
- o_data  output  ROWS*DATA_WIDTH  skewed per-row words
- o_data_valid  output  ROWS  skewed per-row valids
- o_busy  output  1  high in STREAM or DRAIN
- o_drain_done  output  1  one-cycle pulse when the last skewed word has left lane ROWS-1
- o_vec_count  output  ADDR_WIDTH  number of accepted cycles with any valid bit set; saturating
- o_overrun  output  1  sticky; set if any i_data_valid bit is high while i_stall is high

Behaviour:
- Reset (async, i_nrst=0):
  - all lane registers and o_data cleared to 0; o_data_valid = 0
  - o_busy = 0, o_drain_done = 0, o_vec_count = 0, o_overrun = 0
  - FSM enters IDLE
- Lane structure:
  - Lane r has r+1 register stages (data plus valid), so row r latency is r+1 cycles.
  - Row 0 therefore appears 1 cycle after input, and row ROWS-1 appears ROWS cycles after input.
  - Outputs are registered; there is no combinational path from input to output.
- Advance condition: adv = i_en & ~i_stall.
  - When adv=1, every lane shifts one stage.
  - When adv=0, every lane holds its contents, o_data holds its value, and o_data_valid is forced to 0 for that cycle.
  - While adv=0, input data is not captured; a stage-0 bubble is inserted only when adv=1 and the valid is low.
- Overrun: if i_stall=1 and i_data_valid!=0, o_overrun is set and stays set until reset or i_reg_clear. The offending data is dropped.
- Counter:
  - o_vec_count increments when adv=1 and |i_data_valid=1.
  - It saturates at 2^ADDR_WIDTH-1 and does not wrap.
- FSM states:
  - IDLE:
    - go to STREAM when adv=1 and |i_data_valid=1
    - go to DRAIN when i_route_done=1 (an empty tile still drains)
  - STREAM:
    - go to DRAIN on i_route_done=1
    - the vector presented in the same cycle as i_route_done is still accepted
  - DRAIN:
    - a drain counter is loaded with ROWS on entry and decrements on each adv=1 cycle
    - new valid inputs in DRAIN are accepted into the lanes (they are not dropped) but do not extend the drain
    - when the counter reaches 0, pulse o_drain_done for 1 cycle and return to IDLE
  - Stall cycles do not decrement the drain counter.
  - i_route_done received in DRAIN or IDLE-after-DRAIN is treated as a fresh tile end and restarts the drain counter at ROWS.
- o_busy = (state != IDLE).
- i_reg_clear:
  - has the same effect as reset, but synchronous
  - takes priority over all other inputs in the same cycle, including i_route_done and valid data
- Mid-operation reset or clear: in-flight lane contents are discarded, and no o_drain_done pulse is produced for the aborted tile.

Test Plan:
- Single vector, ROWS=4: data {r3=0x44, r2=0x33, r1=0x22, r0=0x11} with valid=4'hF at cycle 0 -> o_data_valid[0] at cycle 1 with 0x11, [1] at cycle 2 with 0x22, [2] at cycle 3 with 0x33, [3] at cycle 4 with 0x44; o_vec_count=1.
- Stream 8 vectors with i_route_done on the 8th, no stall -> outputs form a continuous diagonal; o_drain_done pulses exactly 4 cycles after the i_route_done cycle; o_busy then falls; o_vec_count=8.
- Stall 2 cycles mid-stream with valid held low -> all o_data_valid=0 and o_data frozen during the stall; the sequence resumes with no lost or duplicated words; the drain pulse is delayed by exactly 2 cycles; o_overrun stays 0.
- Valid=4'h1 asserted while i_stall=1 -> o_overrun=1 and remains set through subsequent traffic; the word never appears on o_data; the counter does not increment.
- i_route_done with no prior data -> FSM goes IDLE->DRAIN; o_drain_done pulses after 4 cycles; o_vec_count stays 0.
- i_reg_clear asserted while 2 words are in flight in DRAIN -> next cycle all outputs are 0; no o_drain_done pulse; the FSM is in IDLE. Repeat the same check with i_nrst asserted asynchronously mid-cycle.

Source files
------------

// File: rtl/input_skew_buffer.sv
// Skews per-row activations so row r reaches the PE array r cycles after row 0.
// Tracks the end of a tile and reports when the delay lines have drained.

module isb_lane #(
  parameter int DW    = 8,
  parameter int DEPTH = 1
) (
  input  logic          i_clk,
  input  logic          i_nrst,
  input  logic          clr,
  input  logic          adv,
  input  logic [DW-1:0] in_data,
  input  logic          in_vld,
  output logic [DW-1:0] out_data,
  output logic          out_vld
);
  logic [DEPTH-1:0][DW-1:0] dat_pipe;
  logic [DEPTH-1:0]         vld_pipe;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      dat_pipe <= '0;
      vld_pipe <= '0;
    end else if (clr) begin
      dat_pipe <= '0;
      vld_pipe <= '0;
    end else if (adv) begin
      dat_pipe[0] <= in_data;
      vld_pipe[0] <= in_vld;
      for (int k = 1; k < DEPTH; k++) begin
        dat_pipe[k] <= dat_pipe[k-1];
        vld_pipe[k] <= vld_pipe[k-1];
      end
    end else begin
      // Held word was already presented once; hide it until the lane moves again.
      vld_pipe[DEPTH-1] <= 1'b0;
    end
  end

  assign out_data = dat_pipe[DEPTH-1];
  assign out_vld  = vld_pipe[DEPTH-1];
endmodule

module input_skew_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 4,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                                i_clk,
  input  logic                                i_nrst,
  input  logic                                i_en,
  input  logic                                i_reg_clear,
  input  logic                                i_stall,
  input  logic [ROWS-1:0][DATA_WIDTH-1:0]     i_data,
  input  logic [ROWS-1:0]                     i_data_valid,
  input  logic                                i_route_done,
  output logic [ROWS-1:0][DATA_WIDTH-1:0]     o_data,
  output logic [ROWS-1:0]                     o_data_valid,
  output logic                                o_busy,
  output logic                                o_drain_done,
  output logic [ADDR_WIDTH-1:0]               o_vec_count,
  output logic                                o_overrun
);
  localparam int CW = $clog2(ROWS + 1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            done_d;
  logic            adv, any_vld;

  assign adv     = i_en & ~i_stall;
  assign any_vld = |i_data_valid;

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    isb_lane #(.DW(DATA_WIDTH), .DEPTH(r + 1)) u_lane (
      .i_clk    (i_clk),
      .i_nrst   (i_nrst),
      .clr      (i_reg_clear),
      .adv      (adv),
      .in_data  (i_data[r]),
      .in_vld   (i_data_valid[r]),
      .out_data (o_data[r]),
      .out_vld  (o_data_valid[r])
    );
  end

  // The route_done cycle itself is the first advance of the drain, so the
  // counter holds the advances still needed before the last word exits.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (i_en) begin
      case (state_q)
        IDLE: begin
          if (i_route_done) begin
            state_d = DRAIN;
            cnt_d   = CW'(ROWS - 1);
          end else if (adv && any_vld) begin
            state_d = STREAM;
          end
        end
        STREAM: begin
          if (i_route_done) begin
            state_d = DRAIN;
            cnt_d   = CW'(ROWS - 1);
          end
        end
        DRAIN: begin
          if (i_route_done) begin
            cnt_d = CW'(ROWS - 1);
          end else if (adv) begin
            if (cnt_q <= CW'(1)) begin
              done_d  = 1'b1;
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      o_drain_done <= 1'b0;
      o_vec_count  <= '0;
      o_overrun    <= 1'b0;
    end else if (i_reg_clear) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      o_drain_done <= 1'b0;
      o_vec_count  <= '0;
      o_overrun    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      o_drain_done <= done_d;
      if (adv && any_vld && (o_vec_count != '1))
        o_vec_count <= o_vec_count + 1'b1;
      if (i_stall && any_vld)
        o_overrun <= 1'b1;
    end
  end

  assign o_busy = (state_q != IDLE);
endmodule

// File: tb/tb_input_skew_buffer.sv
// Directed bench for input_skew_buffer: expected words and drain pulses are
// queued at issue time and retired by an output-side monitor.

module tb_input_skew_buffer;
  localparam int ROWS = 4, DW = 8, AW = 8;

  logic                     clk = 1'b0;
  logic                     nrst = 1'b0;
  logic                     en = 1'b1, clr = 1'b0, stall = 1'b0, rd = 1'b0;
  logic [ROWS-1:0][DW-1:0]  din = '0;
  logic [ROWS-1:0]          dv = '0;
  logic [ROWS-1:0][DW-1:0]  dout;
  logic [ROWS-1:0]          dout_v;
  logic                     busy, done, ovr;
  logic [AW-1:0]            vcnt;

  input_skew_buffer #(.DATA_WIDTH(DW), .ROWS(ROWS), .ADDR_WIDTH(AW)) dut (
    .i_clk(clk), .i_nrst(nrst), .i_en(en), .i_reg_clear(clr), .i_stall(stall),
    .i_data(din), .i_data_valid(dv), .i_route_done(rd),
    .o_data(dout), .o_data_valid(dout_v), .o_busy(busy), .o_drain_done(done),
    .o_vec_count(vcnt), .o_overrun(ovr)
  );

  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] d; int due; } exp_t;
  exp_t lq [ROWS][$];
  int   dq [$];
  int   cyc = 0, nadv = 0, total = 0, bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic flush();
    for (int r = 0; r < ROWS; r++) lq[r].delete();
  endtask

  // Expected-word model: an accepted word on row r leaves after r+1 advances.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (!nrst || clr) flush();
    else if (en && !stall) begin
      nadv++;
      for (int r = 0; r < ROWS; r++)
        if (dv[r]) lq[r].push_back('{d: din[r], due: nadv + r});
    end
  end

  // Monitor
  initial forever begin
    @(negedge clk);
    for (int r = 0; r < ROWS; r++) begin
      if (dout_v[r]) begin
        if (lq[r].size() == 0) begin
          total++; bad++;
          $display("FAIL row%0d_unexpected: got %0h want none (cyc %0d)", r, dout[r], cyc);
        end else begin
          exp_t e;
          e = lq[r].pop_front();
          chk($sformatf("row%0d_data", r), 64'(dout[r]), 64'(e.d));
          chk($sformatf("row%0d_time", r), 64'(nadv), 64'(e.due));
        end
      end
    end
    if (done) begin
      if (dq.size() == 0) begin
        total++; bad++;
        $display("FAIL drain_unexpected: got pulse want none (cyc %0d)", cyc);
      end else chk("drain_cycle", 64'(cyc), 64'(dq.pop_front()));
    end
  end

  task automatic step(input logic [3:0] v, input logic [31:0] d, input logic r_d,
                      input logic st, input logic cl);
    dv = v; din = d; rd = r_d; stall = st; clr = cl;
    @(posedge clk); #1;
    dv = '0; rd = 1'b0; stall = 1'b0; clr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic settle(input string nm);
    idle(6);
    chk({nm, "_drain_pending"}, 64'(dq.size()), 64'd0);
    for (int r = 0; r < ROWS; r++)
      chk($sformatf("%s_row%0d_pending", nm, r), 64'(lq[r].size()), 64'd0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_data"}, 64'(dout), 64'd0);
    chk({nm, "_valid"}, 64'(dout_v), 64'd0);
    chk({nm, "_busy"}, 64'(busy), 64'd0);
    chk({nm, "_done"}, 64'(done), 64'd0);
    chk({nm, "_count"}, 64'(vcnt), 64'd0);
    chk({nm, "_overrun"}, 64'(ovr), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] saved;
    int c;
    #23 nrst = 1'b0;
    chk_zero("reset");
    @(posedge clk); #1; nrst = 1'b1;
    idle(1);

    // single vector
    step(4'hF, 32'h44332211, 1'b0, 1'b0, 1'b0);
    chk("single_count", 64'(vcnt), 64'd1);
    chk("single_busy", 64'(busy), 64'd1);
    idle(4);
    c = cyc; dq.push_back(c + 4);
    step(4'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    settle("single");
    chk("single_idle", 64'(busy), 64'd0);
    step(4'h0, 32'h0, 1'b0, 1'b0, 1'b1);

    // 8-vector stream, route_done on the last
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin c = cyc; dq.push_back(c + 4); end
      step(4'hF, 32'h01020304 + 32'(i) * 32'h10101010, i == 7, 1'b0, 1'b0);
    end
    idle(2);
    chk("stream_busy_c3", 64'(busy), 64'd1);
    idle(1);
    chk("stream_busy_c4", 64'(busy), 64'd0);
    chk("stream_count", 64'(vcnt), 64'd8);
    settle("stream");
    step(4'h0, 32'h0, 1'b0, 1'b0, 1'b1);

    // 2-cycle stall mid-stream
    for (int i = 0; i < 4; i++) step(4'hF, 32'hA0B0C0D0 + 32'(i), 1'b0, 1'b0, 1'b0);
    saved = dout;
    for (int i = 0; i < 2; i++) begin
      step(4'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      chk("stall_valid", 64'(dout_v), 64'd0);
      chk("stall_frozen", 64'(dout), 64'(saved));
    end
    for (int i = 4; i < 8; i++) begin
      if (i == 7) begin c = cyc; dq.push_back(c + 4); end
      step(4'hF, 32'hA0B0C0D0 + 32'(i), i == 7, 1'b0, 1'b0);
    end
    settle("stall");
    chk("stall_overrun", 64'(ovr), 64'd0);
    chk("stall_count", 64'(vcnt), 64'd8);
    step(4'h0, 32'h0, 1'b0, 1'b0, 1'b1);

    // overrun: valid while stalled is dropped and flagged
    step(4'h1, 32'h000000EE, 1'b0, 1'b1, 1'b0);
    chk("ovr_set", 64'(ovr), 64'd1);
    chk("ovr_count", 64'(vcnt), 64'd0);
    for (int i = 0; i < 3; i++) step(4'hF, 32'h55667788 + 32'(i), 1'b0, 1'b0, 1'b0);
    chk("ovr_sticky", 64'(ovr), 64'd1);
    chk("ovr_count_after", 64'(vcnt), 64'd3);
    settle("ovr");
    step(4'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("clear_overrun", 64'(ovr), 64'd0);

    // empty tile
    c = cyc; dq.push_back(c + 4);
    step(4'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("empty_busy", 64'(busy), 64'd1);
    settle("empty");
    chk("empty_count", 64'(vcnt), 64'd0);
    chk("empty_idle", 64'(busy), 64'd0);

    // clear in DRAIN with words in flight: no pulse
    step(4'hF, 32'h11111111, 1'b0, 1'b0, 1'b0);
    step(4'hF, 32'h22222222, 1'b1, 1'b0, 1'b0);
    chk("clr_pre_busy", 64'(busy), 64'd1);
    step(4'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk_zero("clr_abort");
    settle("clr_abort");

    // async reset in DRAIN with words in flight: no pulse
    step(4'hF, 32'h33333333, 1'b0, 1'b0, 1'b0);
    step(4'hF, 32'h44444444, 1'b1, 1'b0, 1'b0);
    #2 nrst = 1'b0;
    flush();
    #1 chk_zero("rst_abort");
    idle(1);
    nrst = 1'b1;
    settle("rst_abort");

    // counter saturation
    for (int i = 0; i < 260; i++) step(4'hF, 32'(i), 1'b0, 1'b0, 1'b0);
    chk("sat_count", 64'(vcnt), 64'd255);
    step(4'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("sat_clear", 64'(vcnt), 64'd0);
    settle("end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
